// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: default widths, vectors and FSM states.
package pc_gen_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0004;
    localparam int          INSTR_BYTES_DEF  = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator (master) and instruction memory (slave).
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);

    logic            fetch_valid_o;
    logic            fetch_ready_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus_o;

    modport master (
        output fetch_valid_o,
        output pc_o,
        output pc_plus_o,
        input  fetch_ready_i
    );

    modport slave (
        input  fetch_valid_o,
        input  pc_o,
        input  pc_plus_o,
        output fetch_ready_i
    );

endinterface

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC priority mux: exception > eret > redirect > stall > accepted fetch.
// With PC_MISALIGN_EN defined, misaligned redirect/eret targets trap instead of being masked.
module pc_gen_next_sel
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] EXC_VECTOR  = XLEN'(EXC_VECTOR_DEF),
    parameter int              INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus,
    input  logic [XLEN-1:0] i_epc,
    input  logic            i_exc_valid,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic            i_eret,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_stall,
    input  logic            i_fetch_fire,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_next_epc,
`ifdef PC_MISALIGN_EN
    output logic            o_misalign,
`endif
    output logic            o_epc_we
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] w_target;
    logic            w_take;

    // eret outranks redirect, so it owns the shared target path when both fire.
    assign w_target = i_eret ? i_epc : i_redirect_pc;
    assign w_take   = i_eret || i_redirect_valid;

    always_comb begin
        o_next_pc  = i_pc;
        o_next_epc = i_exc_pc;
        o_epc_we   = 1'b0;
`ifdef PC_MISALIGN_EN
        o_misalign = 1'b0;
`endif
        if (i_exc_valid) begin
            o_next_pc  = EXC_VECTOR;
            o_next_epc = i_exc_pc;
            o_epc_we   = 1'b1;
        end else if (w_take) begin
`ifdef PC_MISALIGN_EN
            if ((w_target & ALIGN_MASK) != '0) begin
                o_next_pc  = EXC_VECTOR;
                o_next_epc = w_target;
                o_epc_we   = 1'b1;
                o_misalign = 1'b1;
            end else begin
                o_next_pc = w_target;
            end
`else
            o_next_pc = w_target & ~ALIGN_MASK;
`endif
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end else if (i_fetch_fire) begin
            o_next_pc = i_pc_plus;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: PC/EPC registers, BOOT/RUN/HALT FSM and the fetch request.
// Optional PC_MISALIGN_EN adds misaligned-target trapping and the misalign_o pulse.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(EXC_VECTOR_DEF),
    parameter int              INSTR_BYTES  = INSTR_BYTES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            exc_valid_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic            eret_i,
    pc_gen_if.master        fetch_if,
    output logic [XLEN-1:0] epc_o,
`ifdef PC_MISALIGN_EN
    output logic            misalign_o,
`endif
    output logic            halted_o
);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_halted;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_next_epc;
    logic            w_epc_we;
    logic            w_fetch_valid;
    logic [XLEN-1:0] w_pc_plus;
`ifdef PC_MISALIGN_EN
    logic            r_misalign;
    logic            w_misalign;
`endif

    assign w_fetch_valid = (r_state == ST_RUN) && !stall_i;
    assign w_pc_plus     = r_pc + XLEN'(INSTR_BYTES);

    assign fetch_if.fetch_valid_o = w_fetch_valid;
    assign fetch_if.pc_o          = r_pc;
    assign fetch_if.pc_plus_o     = w_pc_plus;
    assign epc_o                  = r_epc;
    assign halted_o               = r_halted;
`ifdef PC_MISALIGN_EN
    assign misalign_o             = r_misalign;
`endif

    pc_gen_next_sel #(
        .XLEN        (XLEN),
        .EXC_VECTOR  (EXC_VECTOR),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .i_pc             (r_pc),
        .i_pc_plus        (w_pc_plus),
        .i_epc            (r_epc),
        .i_exc_valid      (exc_valid_i),
        .i_exc_pc         (exc_pc_i),
        .i_eret           (eret_i),
        .i_redirect_valid (redirect_valid_i),
        .i_redirect_pc    (redirect_pc_i),
        .i_stall          (stall_i),
        .i_fetch_fire     (w_fetch_valid && fetch_if.fetch_ready_i),
        .o_next_pc        (w_next_pc),
        .o_next_epc       (w_next_epc),
`ifdef PC_MISALIGN_EN
        .o_misalign       (w_misalign),
`endif
        .o_epc_we         (w_epc_we)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_VECTOR;
            r_epc    <= '0;
            r_halted <= 1'b0;
`ifdef PC_MISALIGN_EN
            r_misalign <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    // The RUN-cycle update still lands when halt_i arrives with it.
                    r_pc <= w_next_pc;
                    if (w_epc_we) r_epc <= w_next_epc;
`ifdef PC_MISALIGN_EN
                    r_misalign <= w_misalign;
`endif
                    if (halt_i) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen; covers PC_MISALIGN_EN when the macro is defined.
`timescale 1ns/1ps
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        halt_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        exc_valid_i;
    logic [31:0] exc_pc_i;
    logic        eret_i;
    logic [31:0] epc_o;
    logic        halted_o;
`ifdef PC_MISALIGN_EN
    logic        misalign_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pc_gen_if #(.XLEN(32)) fetch_if ();

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h8000_0004),
        .INSTR_BYTES  (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .halt_i           (halt_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .exc_valid_i      (exc_valid_i),
        .exc_pc_i         (exc_pc_i),
        .eret_i           (eret_i),
        .fetch_if         (fetch_if),
        .epc_o            (epc_o),
`ifdef PC_MISALIGN_EN
        .misalign_o       (misalign_o),
`endif
        .halted_o         (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        stall_i          = 1'b0;
        halt_i           = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        exc_valid_i      = 1'b0;
        exc_pc_i         = '0;
        eret_i           = 1'b0;
        fetch_if.fetch_ready_i = 1'b1;

        #12;
        check_eq("rst_pc",     fetch_if.pc_o, 32'h0);
        check_eq("rst_epc",    epc_o, 32'h0);
        check_eq("rst_valid",  {31'd0, fetch_if.fetch_valid_o}, 32'd0);
        check_eq("rst_halted", {31'd0, halted_o}, 32'd0);
        reset = 1'b1;
        #1;
        check_eq("boot_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd0);

        // Sequential fetch with ready held high.
        step();
        check_eq("run_pc0",    fetch_if.pc_o, 32'h0);
        check_eq("run_valid",  {31'd0, fetch_if.fetch_valid_o}, 32'd1);
        step(); check_eq("seq_pc4", fetch_if.pc_o, 32'h4);
        step(); check_eq("seq_pc8", fetch_if.pc_o, 32'h8);
        step(); check_eq("seq_pcc", fetch_if.pc_o, 32'hC);
        step(); check_eq("seq_pc10", fetch_if.pc_o, 32'h10);

        // Backpressure keeps the request and PC stable.
        fetch_if.fetch_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_pc",    fetch_if.pc_o, 32'h10);
            check_eq("bp_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd1);
        end
        fetch_if.fetch_ready_i = 1'b1;
        step(); check_eq("bp_release", fetch_if.pc_o, 32'h14);

        // Exception beats a simultaneous redirect.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
        exc_valid_i = 1'b1; exc_pc_i = 32'h20;
        step();
        check_eq("exc_pc",  fetch_if.pc_o, 32'h8000_0004);
        check_eq("exc_epc", epc_o, 32'h20);
        redirect_valid_i = 1'b0; exc_valid_i = 1'b0;
        eret_i = 1'b1;
        step();
        check_eq("eret_pc",  fetch_if.pc_o, 32'h20);
        check_eq("eret_epc", epc_o, 32'h20);
        eret_i = 1'b0;

        // Redirect wins over stall; stall alone holds.
        stall_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h100;
        #1;
        check_eq("stall_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd0);
        step();
        check_eq("stall_redir", fetch_if.pc_o, 32'h100);
        redirect_valid_i = 1'b0;
        step();
        check_eq("stall_hold",   fetch_if.pc_o, 32'h100);
        check_eq("stall_valid2", {31'd0, fetch_if.fetch_valid_o}, 32'd0);
        stall_i = 1'b0;
        #1;
        check_eq("unstall_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd1);

        // Misaligned redirect target.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h42;
        step();
        redirect_valid_i = 1'b0;
`ifdef PC_MISALIGN_EN
        check_eq("mis_pc",    fetch_if.pc_o, 32'h8000_0004);
        check_eq("mis_epc",   epc_o, 32'h42);
        check_eq("mis_pulse", {31'd0, misalign_o}, 32'd1);
        step();
        check_eq("mis_clear", {31'd0, misalign_o}, 32'd0);
        check_eq("mis_next",  fetch_if.pc_o, 32'h8000_0008);
`else
        check_eq("align_pc",  fetch_if.pc_o, 32'h40);
        check_eq("align_epc", epc_o, 32'h20);
`endif

        // Wrap-around at the top of the address space.
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_valid_i = 1'b0;
        check_eq("wrap_top",  fetch_if.pc_o, 32'hFFFF_FFFC);
        check_eq("wrap_plus", fetch_if.pc_plus_o, 32'h0);
        step();
        check_eq("wrap_pc",   fetch_if.pc_o, 32'h0);

        // Halt with a simultaneous exception, then everything is ignored.
        halt_i = 1'b1; exc_valid_i = 1'b1; exc_pc_i = 32'h24;
        step();
        halt_i = 1'b0; exc_valid_i = 1'b0;
        check_eq("halt_flag",  {31'd0, halted_o}, 32'd1);
        check_eq("halt_pc",    fetch_if.pc_o, 32'h8000_0004);
        check_eq("halt_epc",   epc_o, 32'h24);
        check_eq("halt_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd0);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        exc_valid_i = 1'b1; exc_pc_i = 32'h99; eret_i = 1'b1;
        step(); step();
        redirect_valid_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
        check_eq("halt_frozen_pc",  fetch_if.pc_o, 32'h8000_0004);
        check_eq("halt_frozen_epc", epc_o, 32'h24);

        // Reset leaves HALT.
        reset = 1'b0;
        #1;
        check_eq("unhalt_flag", {31'd0, halted_o}, 32'd0);
        check_eq("unhalt_epc",  epc_o, 32'h0);
        reset = 1'b1;
        step();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h30;
        step();
        redirect_valid_i = 1'b0;
        check_eq("mid_pc",    fetch_if.pc_o, 32'h30);
        check_eq("mid_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd1);

        // Asynchronous reset mid-stream, away from any clock edge.
        reset = 1'b0;
        #1;
        check_eq("async_pc",    fetch_if.pc_o, 32'h0);
        check_eq("async_valid", {31'd0, fetch_if.fetch_valid_o}, 32'd0);
        reset = 1'b1;
        step();
        check_eq("reboot_pc", fetch_if.pc_o, 32'h0);
        step();
        check_eq("reboot_seq", fetch_if.pc_o, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
